// File: rtl/fp_add_arb_pkg.sv
// fp_add_arb_pkg: shared constants for the FP adder arbiter slice.
//   FP_ADD_LATENCY - cycles from fpu_start high to fpu_done high on the shared adder
//   ST_*           - per-requester sequencer states
//   clog2_min1     - index width helper that never returns 0
package fp_add_arb_pkg;

  localparam int unsigned FP_ADD_LATENCY = 5;

  localparam logic [1:0] ST_IDLE = 2'd0;
  localparam logic [1:0] ST_BUSY = 2'd1;
  localparam logic [1:0] ST_RESP = 2'd2;

  function automatic int unsigned clog2_min1(input int unsigned n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/rr_arbiter.sv
// rr_arbiter: combinational round-robin arbiter.
//   req   in  N      request vector
//   ptr   in  PTR_W  highest-priority index this cycle (must be < N)
//   grant out N      one-hot grant, zero when no request
module rr_arbiter
  import fp_add_arb_pkg::*;
#(
  parameter int unsigned N     = 4,
  parameter int unsigned PTR_W = clog2_min1(N)
) (
  input  logic [N-1:0]     req,
  input  logic [PTR_W-1:0] ptr,
  output logic [N-1:0]     grant
);

  logic             found;
  logic [PTR_W-1:0] idx;
  int unsigned      pos;

  // Walk from ptr upward with wrap; first requester found wins.
  always_comb begin
    grant = '0;
    found = 1'b0;
    idx   = '0;
    pos   = 0;
    for (int unsigned off = 0; off < N; off++) begin
      pos = 32'(ptr) + off;
      if (pos >= N) pos = pos - N;
      idx = PTR_W'(pos);
      if (!found && req[idx]) begin
        grant[idx] = 1'b1;
        found      = 1'b1;
      end
    end
  end

endmodule

// File: rtl/fp_add_arb.sv
// fp_add_arb: shares one pipelined FP adder between N_REQ requesters.
//   req_valid/req_ready/req_op_a/req_op_b - per-requester operand handshake (packed lanes)
//   rsp_valid/rsp_ready/rsp_res           - per-requester one-entry result register
//   fpu_start/fpu_op_a/fpu_op_b           - registered issue to the adder
//   fpu_done/fpu_res                      - adder result return
//   inflight                              - ops issued and not yet captured
//   err                                   - sticky: fpu_done disagreed with the tag line
module fp_add_arb
  import fp_add_arb_pkg::*;
#(
  parameter int unsigned DATA_W  = 32,
  parameter int unsigned N_REQ   = 4,
  parameter int unsigned LATENCY = FP_ADD_LATENCY
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic [N_REQ-1:0]          req_valid,
  output logic [N_REQ-1:0]          req_ready,
  input  logic [N_REQ*DATA_W-1:0]   req_op_a,
  input  logic [N_REQ*DATA_W-1:0]   req_op_b,
  output logic [N_REQ-1:0]          rsp_valid,
  input  logic [N_REQ-1:0]          rsp_ready,
  output logic [N_REQ*DATA_W-1:0]   rsp_res,
  output logic                      fpu_start,
  output logic [DATA_W-1:0]         fpu_op_a,
  output logic [DATA_W-1:0]         fpu_op_b,
  input  logic                      fpu_done,
  input  logic [DATA_W-1:0]         fpu_res,
  output logic [$clog2(N_REQ+1)-1:0] inflight,
  output logic                      err
);

  localparam int unsigned ID_W  = clog2_min1(N_REQ);
  localparam int unsigned CNT_W = $clog2(N_REQ+1);

  logic [ID_W-1:0]         ptr_q, ptr_d;
  logic [1:0]              state_q [N_REQ];
  logic [1:0]              state_d [N_REQ];
  logic [N_REQ-1:0]        eligible, grant;
  logic                    any_grant;
  logic [ID_W-1:0]         gnt_id;
  logic                    fpu_start_q, fpu_start_d;
  logic [DATA_W-1:0]       op_a_q, op_a_d, op_b_q, op_b_d;
  logic [ID_W-1:0]         iss_id_q, iss_id_d;
  logic [LATENCY-1:0]      tag_v_q, tag_v_d;
  logic [ID_W-1:0]         tag_id_q [LATENCY];
  logic [ID_W-1:0]         tag_id_d [LATENCY];
  logic                    tag_out_v;
  logic [ID_W-1:0]         tag_out_id;
  logic [N_REQ*DATA_W-1:0] rsp_res_q, rsp_res_d;
  logic [CNT_W-1:0]        inflight_q, inflight_d;
  logic                    err_q, err_d;

  // Only idle requesters compete; nothing is granted while in reset.
  always_comb begin
    eligible = '0;
    for (int unsigned i = 0; i < N_REQ; i++)
      eligible[i] = req_valid[i] && (state_q[i] == ST_IDLE) && !rst;
  end

  rr_arbiter #(.N(N_REQ), .PTR_W(ID_W)) u_arb (
    .req   (eligible),
    .ptr   (ptr_q),
    .grant (grant)
  );

  // One-hot grant to index.
  always_comb begin
    gnt_id = '0;
    for (int unsigned i = 0; i < N_REQ; i++)
      if (grant[i]) gnt_id = ID_W'(i);
  end

  assign any_grant  = |grant;
  assign tag_out_v  = tag_v_q[LATENCY-1];
  assign tag_out_id = tag_id_q[LATENCY-1];

  // Pointer, issue registers, tag line, counters and error flag.
  always_comb begin
    ptr_d       = ptr_q;
    fpu_start_d = any_grant;
    op_a_d      = op_a_q;
    op_b_d      = op_b_q;
    iss_id_d    = iss_id_q;
    inflight_d  = inflight_q;
    err_d       = err_q | (tag_out_v != fpu_done);
    if (any_grant) begin
      ptr_d    = (32'(gnt_id) == N_REQ - 1) ? '0 : ID_W'(32'(gnt_id) + 1);
      op_a_d   = req_op_a[32'(gnt_id)*DATA_W +: DATA_W];
      op_b_d   = req_op_b[32'(gnt_id)*DATA_W +: DATA_W];
      iss_id_d = gnt_id;
    end
    // Stage 0 loads alongside the issue pulse so the last stage lines up with fpu_done.
    tag_v_d[0]  = fpu_start_q;
    tag_id_d[0] = iss_id_q;
    for (int unsigned s = 1; s < LATENCY; s++) begin
      tag_v_d[s]  = tag_v_q[s-1];
      tag_id_d[s] = tag_id_q[s-1];
    end
    case ({any_grant, tag_out_v})
      2'b10:   inflight_d = inflight_q + CNT_W'(1);
      2'b01:   inflight_d = inflight_q - CNT_W'(1);
      default: inflight_d = inflight_q;
    endcase
  end

  // Per-requester sequencer and response capture; capture trusts the tag line.
  always_comb begin
    rsp_res_d = rsp_res_q;
    for (int unsigned i = 0; i < N_REQ; i++) begin
      state_d[i] = state_q[i];
      case (state_q[i])
        ST_IDLE: if (grant[i]) state_d[i] = ST_BUSY;
        ST_BUSY: if (tag_out_v && (tag_out_id == ID_W'(i))) begin
          state_d[i] = ST_RESP;
          rsp_res_d[i*DATA_W +: DATA_W] = fpu_res;
        end
        ST_RESP: if (rsp_ready[i]) state_d[i] = ST_IDLE;
        default: state_d[i] = ST_IDLE;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      ptr_q       <= '0;
      fpu_start_q <= 1'b0;
      op_a_q      <= '0;
      op_b_q      <= '0;
      iss_id_q    <= '0;
      tag_v_q     <= '0;
      rsp_res_q   <= '0;
      inflight_q  <= '0;
      err_q       <= 1'b0;
      for (int unsigned s = 0; s < LATENCY; s++) tag_id_q[s] <= '0;
      for (int unsigned i = 0; i < N_REQ; i++) state_q[i] <= ST_IDLE;
    end else begin
      ptr_q       <= ptr_d;
      fpu_start_q <= fpu_start_d;
      op_a_q      <= op_a_d;
      op_b_q      <= op_b_d;
      iss_id_q    <= iss_id_d;
      tag_v_q     <= tag_v_d;
      rsp_res_q   <= rsp_res_d;
      inflight_q  <= inflight_d;
      err_q       <= err_d;
      for (int unsigned s = 0; s < LATENCY; s++) tag_id_q[s] <= tag_id_d[s];
      for (int unsigned i = 0; i < N_REQ; i++) state_q[i] <= state_d[i];
    end
  end

  always_comb begin
    rsp_valid = '0;
    for (int unsigned i = 0; i < N_REQ; i++)
      rsp_valid[i] = (state_q[i] == ST_RESP);
  end

  assign req_ready = grant;
  assign rsp_res   = rsp_res_q;
  assign fpu_start = fpu_start_q;
  assign fpu_op_a  = op_a_q;
  assign fpu_op_b  = op_b_q;
  assign inflight  = inflight_q;
  assign err       = err_q;

endmodule

// File: tb/tb_fp_add_arb.sv
// tb_fp_add_arb: directed bench for fp_add_arb with a pipelined adder model.
module tb_fp_add_arb;

  localparam int unsigned DW  = 32;
  localparam int unsigned NR  = 4;
  localparam int unsigned LAT = 5;

  logic              clk = 1'b0;
  logic              rst;
  logic [NR-1:0]     req_valid, req_ready, rsp_valid, rsp_ready;
  logic [NR*DW-1:0]  req_op_a, req_op_b, rsp_res;
  logic              fpu_start, fpu_done, err;
  logic [DW-1:0]     fpu_op_a, fpu_op_b, fpu_res;
  logic [2:0]        inflight;

  int errors = 0;
  int checks = 0;

  always #5 clk = ~clk;

  fp_add_arb #(.DATA_W(DW), .N_REQ(NR), .LATENCY(LAT)) dut (
    .clk(clk), .rst(rst),
    .req_valid(req_valid), .req_ready(req_ready),
    .req_op_a(req_op_a), .req_op_b(req_op_b),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_res(rsp_res),
    .fpu_start(fpu_start), .fpu_op_a(fpu_op_a), .fpu_op_b(fpu_op_b),
    .fpu_done(fpu_done), .fpu_res(fpu_res),
    .inflight(inflight), .err(err)
  );

  // Adder model: fixed latency, sums looked up for the operand pairs used here.
  logic        mdl_v [LAT];
  logic [31:0] mdl_r [LAT];
  int          done_cnt = 0;
  int          drop_at  = -1;

  function automatic logic [31:0] fp_sum(input logic [31:0] a, input logic [31:0] b);
    case ({a, b})
      {32'h3F800000, 32'h40000000}: return 32'h40400000; // 1+2
      {32'h3F800000, 32'h3F800000}: return 32'h40000000; // 1+1
      {32'h40000000, 32'h40000000}: return 32'h40800000; // 2+2
      {32'h40400000, 32'h3F800000}: return 32'h40800000; // 3+1
      {32'h3F000000, 32'h3F000000}: return 32'h3F800000; // 0.5+0.5
      {32'h3FC00000, 32'h40200000}: return 32'h40800000; // 1.5+2.5
      {32'h40800000, 32'h40800000}: return 32'h41000000; // 4+4
      default:                      return a ^ b;
    endcase
  endfunction

  always @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < LAT; i++) mdl_v[i] <= 1'b0;
    end else begin
      mdl_v[0] <= fpu_start;
      mdl_r[0] <= fp_sum(fpu_op_a, fpu_op_b);
      for (int i = 1; i < LAT; i++) begin
        mdl_v[i] <= mdl_v[i-1];
        mdl_r[i] <= mdl_r[i-1];
      end
      if (mdl_v[LAT-1]) done_cnt <= done_cnt + 1;
    end
  end

  assign fpu_done = mdl_v[LAT-1] && (done_cnt != drop_at);
  assign fpu_res  = mdl_r[LAT-1];

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    assert (got === exp) else begin
      errors++;
      $error("FAIL %s: observed=%h expected=%h", tag, got, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic step_n(input int n);
    for (int i = 0; i < n; i++) step();
  endtask

  task automatic set_op(input int i, input logic [31:0] a, input logic [31:0] b);
    req_op_a[i*DW +: DW] = a;
    req_op_b[i*DW +: DW] = b;
  endtask

  function automatic logic [31:0] lane(input logic [NR*DW-1:0] v, input int i);
    return v[i*DW +: DW];
  endfunction

  initial begin
    #100000;
    $display("FAIL watchdog: bench did not finish in time");
    $fatal(1, "watchdog");
  end

  initial begin
    rst = 1'b1; req_valid = '0; rsp_ready = '0; req_op_a = '0; req_op_b = '0;
    step_n(3);
    rst = 1'b0;

    // Reset state
    chk("rst_req_ready", 32'(req_ready), 32'h0);
    chk("rst_rsp_valid", 32'(rsp_valid), 32'h0);
    chk("rst_fpu_start", 32'(fpu_start), 32'h0);
    chk("rst_inflight",  32'(inflight),  32'h0);
    chk("rst_err",       32'(err),       32'h0);
    chk("rst_rsp_res0",  lane(rsp_res, 0), 32'h0);

    // Single op on lane 0: 1.0 + 2.0
    set_op(0, 32'h3F800000, 32'h40000000);
    req_valid = 4'b0001; #1;
    chk("single_ready", 32'(req_ready), 32'h1);
    step(); req_valid = '0;
    chk("single_start",    32'(fpu_start), 32'h1);
    chk("single_op_a",     fpu_op_a, 32'h3F800000);
    chk("single_op_b",     fpu_op_b, 32'h40000000);
    chk("single_inflight", 32'(inflight), 32'h1);
    step();
    chk("single_start_low", 32'(fpu_start), 32'h0);
    step_n(4);
    chk("single_not_yet", 32'(rsp_valid), 32'h0);
    step();
    chk("single_rsp_valid", 32'(rsp_valid), 32'h1);
    chk("single_rsp_res",   lane(rsp_res, 0), 32'h40400000);
    chk("single_inflight0", 32'(inflight), 32'h0);
    rsp_ready = 4'b0001;
    step();
    chk("single_rsp_drop", 32'(rsp_valid), 32'h0);
    chk("single_err",      32'(err), 32'h0);

    // Reset to bring the pointer back to 0
    rst = 1'b1; step(); rst = 1'b0;

    // Contention: all four lanes at once
    rsp_ready = 4'hF;
    set_op(0, 32'h3F800000, 32'h40000000);
    set_op(1, 32'h40000000, 32'h40000000);
    set_op(2, 32'h3F000000, 32'h3F000000);
    set_op(3, 32'h40800000, 32'h40800000);
    req_valid = 4'hF; #1;
    chk("cont_g0", 32'(req_ready), 32'h1);
    step();
    chk("cont_g1", 32'(req_ready), 32'h2);
    chk("cont_start", 32'(fpu_start), 32'h1);
    chk("cont_op_a0", fpu_op_a, 32'h3F800000);
    chk("cont_op_b0", fpu_op_b, 32'h40000000);
    step();
    chk("cont_g2", 32'(req_ready), 32'h4);
    step();
    chk("cont_g3", 32'(req_ready), 32'h8);
    step(); req_valid = '0;
    chk("cont_inflight4", 32'(inflight), 32'h4);
    chk("cont_op_a3",     fpu_op_a, 32'h40800000);
    step();
    chk("cont_start_low", 32'(fpu_start), 32'h0);
    chk("cont_op_hold",   fpu_op_a, 32'h40800000);
    step_n(2);
    chk("cont_rv0", 32'(rsp_valid), 32'h1);
    chk("cont_res0", lane(rsp_res, 0), 32'h40400000);
    chk("cont_inflight3", 32'(inflight), 32'h3);
    step();
    chk("cont_rv1", 32'(rsp_valid), 32'h2);
    chk("cont_res1", lane(rsp_res, 1), 32'h40800000);
    step();
    chk("cont_rv2", 32'(rsp_valid), 32'h4);
    chk("cont_res2", lane(rsp_res, 2), 32'h3F800000);
    step();
    chk("cont_rv3", 32'(rsp_valid), 32'h8);
    chk("cont_res3", lane(rsp_res, 3), 32'h41000000);
    step();
    chk("cont_drained_rv", 32'(rsp_valid), 32'h0);
    chk("cont_drained_inf", 32'(inflight), 32'h0);

    // Fairness: lanes 0 and 2 held valid, responses consumed immediately
    set_op(0, 32'h3F800000, 32'h3F800000);
    set_op(2, 32'h3FC00000, 32'h40200000);
    req_valid = 4'b0101; #1;
    for (int k = 0; k < 18; k++) begin
      if (k > 0) step();
      chk("fair_grant", 32'(req_ready),
          (k % 8 == 0) ? 32'h1 : (k % 8 == 1) ? 32'h4 : 32'h0);
      if (k == 7) chk("fair_res0", lane(rsp_res, 0), 32'h40000000);
      if (k == 8) chk("fair_res2", lane(rsp_res, 2), 32'h40800000);
    end
    step(); req_valid = '0;
    step_n(8);
    chk("fair_drained", 32'(inflight), 32'h0);

    // Backpressure on lane 1
    rsp_ready = 4'b1101;
    set_op(1, 32'h40400000, 32'h3F800000);
    req_valid = 4'b0010; #1;
    chk("bp_grant1", 32'(req_ready), 32'h2);
    step_n(7);
    chk("bp_rv1", 32'(rsp_valid[1]), 32'h1);
    chk("bp_res1", lane(rsp_res, 1), 32'h40800000);
    set_op(3, 32'h40000000, 32'h40000000);
    req_valid = 4'b1010; #1;
    chk("bp_grant3", 32'(req_ready), 32'h8);
    for (int k = 1; k <= 20; k++) begin
      step();
      if (k == 1) begin req_valid = 4'b0010; #1; end
      chk("bp_hold_rv1",  32'(rsp_valid[1]), 32'h1);
      chk("bp_hold_res1", lane(rsp_res, 1), 32'h40800000);
      chk("bp_no_ready1", 32'(req_ready[1]), 32'h0);
      if (k == 7) begin
        chk("bp_rv3",  32'(rsp_valid[3]), 32'h1);
        chk("bp_res3", lane(rsp_res, 3), 32'h40800000);
      end
    end
    rsp_ready = 4'hF;
    step();
    chk("bp_released", 32'(rsp_valid[1]), 32'h0);
    chk("bp_regrant1", 32'(req_ready), 32'h2);
    step(); req_valid = '0;
    step_n(8);
    chk("bp_drained", 32'(inflight), 32'h0);

    // Reset mid-flight with two ops outstanding
    set_op(0, 32'h3F800000, 32'h40000000);
    set_op(2, 32'h40000000, 32'h40000000);
    req_valid = 4'b0101; #1;
    chk("rmf_grant2", 32'(req_ready), 32'h4);
    step();
    chk("rmf_grant0", 32'(req_ready), 32'h1);
    step(); req_valid = '0;
    chk("rmf_inflight2", 32'(inflight), 32'h2);
    step_n(3);
    rst = 1'b1;
    step();
    chk("rmf_rv",    32'(rsp_valid), 32'h0);
    chk("rmf_inf",   32'(inflight),  32'h0);
    chk("rmf_start", 32'(fpu_start), 32'h0);
    chk("rmf_op_a",  fpu_op_a,       32'h0);
    chk("rmf_ready", 32'(req_ready), 32'h0);
    chk("rmf_err",   32'(err),       32'h0);
    rst = 1'b0;
    for (int k = 0; k < 10; k++) begin
      step();
      chk("rmf_no_stale", 32'(rsp_valid), 32'h0);
      chk("rmf_no_err",   32'(err),       32'h0);
    end
    set_op(1, 32'h3F800000, 32'h40000000);
    req_valid = 4'b0010; #1;
    chk("rmf_fresh_grant", 32'(req_ready), 32'h2);
    step(); req_valid = '0;
    step_n(6);
    chk("rmf_fresh_rv",  32'(rsp_valid), 32'h2);
    chk("rmf_fresh_res", lane(rsp_res, 1), 32'h40400000);
    step();

    // Error: next fpu_done is dropped by the model
    drop_at = done_cnt;
    set_op(0, 32'h3F000000, 32'h3F000000);
    req_valid = 4'b0001; #1;
    chk("err_grant", 32'(req_ready), 32'h1);
    step(); req_valid = '0;
    step_n(5);
    chk("err_done_dropped", 32'(fpu_done), 32'h0);
    chk("err_not_yet",      32'(err),      32'h0);
    step();
    chk("err_set",     32'(err),       32'h1);
    chk("err_rv",      32'(rsp_valid), 32'h1);
    chk("err_res",     lane(rsp_res, 0), 32'h3F800000);
    step_n(3);
    chk("err_sticky",  32'(err), 32'h1);
    set_op(3, 32'h3FC00000, 32'h40200000);
    req_valid = 4'b1000; #1;
    step(); req_valid = '0;
    step_n(6);
    chk("err_after_rv",  32'(rsp_valid), 32'h8);
    chk("err_after_res", lane(rsp_res, 3), 32'h40800000);
    chk("err_still",     32'(err), 32'h1);
    step();
    chk("err_final_inf", 32'(inflight), 32'h0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
